uart_rx: RTL and testbench

UART receive engine: recovers 8N1 frames from the asynchronous serial line `rx` and presents each received byte as a parallel word with a one-cycle `valid` strobe. It derives its own 16x oversampling tick from the system clock, using the same `fqr`/`baud_rate` parameterisation as the transmit-side baud generator. It sits between the board RX pin and the byte-consuming logic.

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver.
// slave: the receiver itself; master: the line driver / byte consumer.
interface uart_rx_if #(
  parameter int data_bits = 8
);
  logic                 rx;
  logic [data_bits-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; valid/frame_err pulse one cycle after the stop-bit sample (tick 152).
// No backpressure: each byte is presented once and held in data until the next good frame.
module uart_rx #(
  parameter int fqr       = 100_000_000,
  parameter int baud_rate = 115200,
  parameter int data_bits = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int clk_div = fqr / (baud_rate * 16);
  localparam int DIV_W   = (clk_div > 2) ? $clog2(clk_div) : 1;
  localparam int NB_W    = $clog2(data_bits + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [DIV_W-1:0]     r_div;
  logic [3:0]           r_ticks;
  logic [NB_W-1:0]      r_nbits;
  logic [data_bits-1:0] r_shift;
  logic [data_bits-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_busy;

  logic w_rx_s;
  logic w_tick;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_div == DIV_W'(clk_div - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_div   <= '0;
      r_ticks <= '0;
      r_nbits <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.rx};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      if (w_tick) r_div <= '0;
      else        r_div <= r_div + 1'b1;

      case (r_state)
        S_IDLE: begin
          // Restart the oversample phase on the detected edge so tick 8 lands mid start bit.
          if (!w_rx_s) begin
            r_div   <= '0;
            r_ticks <= '0;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_tick) begin
            if (r_ticks == 4'd7) begin
              if (!w_rx_s) begin
                r_ticks <= '0;
                r_nbits <= '0;
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_ticks <= r_ticks + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_ticks <= r_ticks + 4'd1;
            if (r_ticks == 4'd15) begin
              r_shift <= {w_rx_s, r_shift[data_bits-1:1]};
              r_nbits <= r_nbits + 1'b1;
              if (r_nbits == NB_W'(data_bits - 1)) r_state <= S_STOP;
            end
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_ticks <= r_ticks + 4'd1;
            if (r_ticks == 4'd15) begin
              if (w_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_WAIT_HIGH;
              end
            end
          end
        end

        // A held-low line (break) must not be mistaken for a fresh start bit.
        S_WAIT_HIGH: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected byte/error events with their exact arrival cycle.
// Runs the receiver from a 50 MHz clock (clk_div 27, same -0.47% bit error as 100 MHz / 54) to keep runs short.
module tb_uart_rx;
  localparam int FQR     = 50_000_000;
  localparam int BAUD    = 115200;
  localparam int CLK_DIV = 27;                         // 50e6 / (115200*16) = 27.13 -> 27
  localparam int BIT     = 434;                        // ideal 50e6/115200 = 434.03 clocks
  localparam int BIT_LO  = 421;                        // -3%
  localparam int BIT_HI  = 447;                        // +3%
  localparam longint LAT = 2 + 152 * CLK_DIV + 1;      // line fall -> output cycle = 4107

  typedef struct {
    bit         err;
    logic [7:0] dat;
    longint     at;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  logic [7:0] held = 8'h00;

  uart_rx_if #(.data_bits(8)) bus();

  uart_rx #(
    .fqr      (FQR),
    .baud_rate(BAUD),
    .data_bits(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // All stimulus is aligned 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int per, input bit stop_bit, input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e.err = !stop_bit;
      e.dat = stop_bit ? b : held;
      e.at  = cyc + LAT;
      sb.push_back(e);
      if (stop_bit) held = b;
    end
    bus.rx = 1'b0;
    idle(per);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle(per);
    end
    bus.rx = stop_bit;
    idle(per);
  endtask

  // Monitor: every output strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.valid || bus.frame_err)) begin
      chk("valid_ferr_exclusive", longint'(bus.valid & bus.frame_err), 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got valid=%b frame_err=%b data=%0h, expected none (cycle %0d)",
                 bus.valid, bus.frame_err, bus.data, cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind_ferr", longint'(bus.frame_err), longint'(e.err));
        chk("data", longint'(bus.data), longint'(e.dat));
        chk("strobe_cycle", cyc, e.at);
        chk("busy_at_strobe", longint'(bus.busy), e.err ? 1 : 0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    realtime t0;
    bit      rose;

    rst    = 1'b1;
    bus.rx = 1'b1;
    idle(3);
    chk("reset_data", longint'(bus.data), 0);
    chk("reset_valid", longint'(bus.valid), 0);
    chk("reset_ferr", longint'(bus.frame_err), 0);
    chk("reset_busy", longint'(bus.busy), 0);
    rst = 1'b0;
    idle(20);

    // 0xA5 nominal, plus busy rise latency after the line edge.
    t0   = $realtime;
    rose = 1'b0;
    fork
      send(8'hA5, BIT, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 10; k++) begin
          idle(1);
          if (bus.busy) begin
            rose = 1'b1;
            break;
          end
        end
        n_cmp++;
        if (!rose || ($realtime - t0) < 20.0 || ($realtime - t0) > 30.0) begin
          n_bad++;
          $display("FAIL busy_rise: got rose=%b after %0t, expected within 20..30", rose, $realtime - t0);
        end
      end
    join
    idle(200);

    // Back-to-back 0x00 / 0xFF with a single stop bit.
    send(8'h00, BIT, 1'b1, 1'b1);
    send(8'hFF, BIT, 1'b1, 1'b1);
    idle(200);

    // Short low glitch, then 0x3C.
    bus.rx = 1'b0;
    idle(100);
    chk("glitch_busy_high", longint'(bus.busy), 1);
    idle(100);
    bus.rx = 1'b1;
    idle(100);
    chk("glitch_busy_low", longint'(bus.busy), 0);
    send(8'h3C, BIT, 1'b1, 1'b1);
    idle(200);

    // Stop bit low, break held, then released.
    send(8'h5A, BIT, 1'b0, 1'b1);
    idle(20000 - BIT);
    chk("break_busy_held", longint'(bus.busy), 1);
    chk("break_data_kept", longint'(bus.data), 8'h3C);
    bus.rx = 1'b1;
    idle(5);
    chk("break_busy_released", longint'(bus.busy), 0);
    idle(200);

    // Reset during data bit 4 of 0xF2 (bits 4..7 and stop are high).
    fork
      send(8'hF2, BIT, 1'b1, 1'b0);
      begin
        idle(5 * BIT + BIT / 2);
        chk("midframe_busy", longint'(bus.busy), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_data", longint'(bus.data), 0);
        chk("midrst_valid", longint'(bus.valid), 0);
        chk("midrst_ferr", longint'(bus.frame_err), 0);
        chk("midrst_busy", longint'(bus.busy), 0);
        held = 8'h00;
      end
    join
    idle(200);
    send(8'hC3, BIT, 1'b1, 1'b1);
    idle(200);

    // Bit-rate tolerance.
    send(8'h96, BIT_LO, 1'b1, 1'b1);
    idle(200);
    send(8'h96, BIT_HI, 1'b1, 1'b1);
    idle(200);

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
